// File: rtl/bp_pkg.sv
// Shared helpers for the branch predictor: index-width derivation, counter init values,
// and the BTB entry field layout {valid, tag, counter, target[30:0]}.
package bp_pkg;

    function automatic int idx_w(input int entries);
        return $clog2(entries);
    endfunction

    // Weakly taken: the value a fresh allocation starts at.
    function automatic int ctr_weak_t(input int ctr_w);
        return 1 << (ctr_w - 1);
    endfunction

    // Weakly not taken: the value every counter holds out of reset.
    function automatic int ctr_weak_nt(input int ctr_w);
        return (1 << (ctr_w - 1)) - 1;
    endfunction

    function automatic int entry_w(input int tag_w, input int ctr_w);
        return 1 + tag_w + ctr_w + 31;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Combinational next value of a CTR_W-bit saturating direction counter.
module sat_counter #(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] cur,
    input  logic             taken,
    output logic [CTR_W-1:0] nxt
);

    always_comb begin
        nxt = cur;
        if (taken && cur != '1)
            nxt = cur + CTR_W'(1);
        else if (!taken && cur != '0)
            nxt = cur - CTR_W'(1);
    end

endmodule

// File: rtl/branch_predictor.sv
// Flop-array BTB with saturating counters, same-cycle lookup and EX-stage mispredict redirect.
// Optional resolved/mispredict statistics counters are built when BP_STATS_EN is defined.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int CTR_W   = 2
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [31:0] if_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        bp_clear,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispred
);

    localparam int IDX_W = idx_w(ENTRIES);
    localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(ctr_weak_t(CTR_W));
    localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_W'(ctr_weak_nt(CTR_W));

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [CTR_W-1:0] ctr;
        logic [30:0]      target;
    } entry_t;

    entry_t           tbl [ENTRIES];
    entry_t           if_ent, ex_ent;
    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             ex_hit;
    logic [CTR_W-1:0] ctr_nxt;
    logic             unused_bits;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign if_ent = tbl[if_idx];
    assign ex_ent = tbl[ex_idx];
    assign ex_hit = ex_ent.valid && (ex_ent.tag == ex_tag);

    // Lookup reads registered state only, so a same-cycle update is never visible here.
    assign pred_hit    = if_ent.valid && (if_ent.tag == if_tag);
    assign pred_taken  = pred_hit && if_ent.ctr[CTR_W-1];
    assign pred_target = {if_pc[31], if_ent.target};

    assign mispredict  = ex_valid && ((ex_taken != ex_pred_taken) ||
                         (ex_taken && (ex_target[30:0] != ex_pred_target[30:0])));
    assign redirect_pc = ex_taken ? {ex_pc[31], ex_target[30:0]}
                                  : {ex_pc[31], ex_pc[30:0] + 31'd4};

    assign unused_bits = ^{if_pc, ex_pred_target[31], ex_target[31]};

    sat_counter #(.CTR_W(CTR_W)) u_ctr (
        .cur   (ex_ent.ctr),
        .taken (ex_taken),
        .nxt   (ctr_nxt)
    );

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++)
                tbl[i] <= '{valid: 1'b0, tag: '0, ctr: CTR_WEAK_NT, target: '0};
        end else if (bp_clear) begin
            for (int i = 0; i < ENTRIES; i++)
                tbl[i].valid <= 1'b0;
        end else if (ex_valid) begin
            if (ex_hit) begin
                tbl[ex_idx].ctr <= ctr_nxt;
                if (ex_taken)
                    tbl[ex_idx].target <= ex_target[30:0];
            end else if (ex_taken) begin
                tbl[ex_idx] <= '{valid: 1'b1, tag: ex_tag, ctr: CTR_WEAK_T, target: ex_target[30:0]};
            end
        end
    end

`ifdef BP_STATS_EN
    // Stats survive bp_clear; only reset zeroes them.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else if (ex_valid) begin
            if (stat_branches != '1)
                stat_branches <= stat_branches + 32'd1;
            if (mispredict && stat_mispred != '1)
                stat_mispred <= stat_mispred + 32'd1;
        end
    end
`else
    assign stat_branches = 32'd0;
    assign stat_mispred  = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor; expectations queue up at drive time and are popped at sampling.
module tb_branch_predictor;

    localparam int ENTRIES = 16;
    localparam int TAG_W   = 8;
    localparam int CTR_W   = 2;
`ifdef BP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        sysclk, reset;
    logic [31:0] if_pc;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        bp_clear, ex_valid, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc, stat_branches, stat_mispred;

    int errors = 0;
    int checks = 0;
    int nb = 0;
    int nm = 0;
    string       sb_tag[$];
    logic [31:0] sb_val[$];
    logic [31:0] alias_pc;

    branch_predictor #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .CTR_W(CTR_W)) dut (
        .sysclk(sysclk), .reset(reset), .if_pc(if_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .bp_clear(bp_clear), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic expect_val(input string t, input logic [31:0] v);
        sb_tag.push_back(t);
        sb_val.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        checks++;
        if (sb_val.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty got=%h", obs);
        end else begin
            t = sb_tag.pop_front();
            e = sb_val.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s got=%h exp=%h", t, obs, e);
            end
        end
    endtask

    task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt, input logic clr,
                           input logic mis, input logic [31:0] rpc);
        @(negedge sysclk);
        ex_valid = 1'b1; ex_pc = pc; ex_taken = tk; ex_target = tgt;
        ex_pred_taken = ptk; ex_pred_target = ptgt; bp_clear = clr;
        expect_val("mispredict", {31'b0, mis});
        expect_val("redirect_pc", rpc);
        nb++;
        if (mis) nm++;
        #2;
        check({31'b0, mispredict});
        check(redirect_pc);
        @(posedge sysclk);
        #1;
        ex_valid = 1'b0;
        bp_clear = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc, input logic hit, input logic tk, input logic [31:0] tgt);
        @(negedge sysclk);
        if_pc = pc;
        expect_val("pred_hit", {31'b0, hit});
        expect_val("pred_taken", {31'b0, tk});
        expect_val("pred_target", tgt);
        expect_val("mispredict_idle", 32'd0);
        #2;
        check({31'b0, pred_hit});
        check({31'b0, pred_taken});
        check(pred_target);
        check({31'b0, mispredict});
    endtask

    task automatic stats_chk();
        expect_val("stat_branches", STATS ? 32'(nb) : 32'd0);
        expect_val("stat_mispred", STATS ? 32'(nm) : 32'd0);
        check(stat_branches);
        check(stat_mispred);
    endtask

    initial begin
        reset = 1'b0; bp_clear = 1'b0; ex_valid = 1'b0; ex_taken = 1'b0; ex_pred_taken = 1'b0;
        ex_pc = '0; ex_target = '0; ex_pred_target = '0; if_pc = 32'h0040_0010;
        alias_pc = 32'h0040_0010 + 32'(ENTRIES * 4);

        // Reset state
        #2;
        expect_val("rst_pred_hit", 32'd0);
        expect_val("rst_pred_taken", 32'd0);
        expect_val("rst_pred_target", 32'd0);
        expect_val("rst_mispredict", 32'd0);
        check({31'b0, pred_hit});
        check({31'b0, pred_taken});
        check(pred_target);
        check({31'b0, mispredict});
        stats_chk();
        @(negedge sysclk);
        reset = 1'b1;

        // First taken resolve allocates weakly taken; ex_* stays stale afterwards with ex_valid low
        resolve(32'h0040_0010, 1, 32'h0040_0100, 0, 32'h0, 0, 1, 32'h0040_0100);
        lookup(32'h0040_0010, 1, 1, 32'h0040_0100);
        stats_chk();

        // Walk the counter down to 0 and hold there
        resolve(32'h0040_0010, 0, 32'h0, 1, 32'h0040_0100, 0, 1, 32'h0040_0014);
        lookup(32'h0040_0010, 1, 0, 32'h0040_0100);
        resolve(32'h0040_0010, 0, 32'h0, 0, 32'h0040_0100, 0, 0, 32'h0040_0014);
        resolve(32'h0040_0010, 0, 32'h0, 0, 32'h0040_0100, 0, 0, 32'h0040_0014);
        resolve(32'h0040_0010, 0, 32'h0, 0, 32'h0040_0100, 0, 0, 32'h0040_0014);
        lookup(32'h0040_0010, 1, 0, 32'h0040_0100);
        // One taken from 0 must leave it not-taken (no wrap at the bottom)
        resolve(32'h0040_0010, 1, 32'h0040_0100, 0, 32'h0040_0100, 0, 1, 32'h0040_0100);
        lookup(32'h0040_0010, 1, 0, 32'h0040_0100);
        resolve(32'h0040_0010, 1, 32'h0040_0200, 0, 32'h0040_0100, 0, 1, 32'h0040_0200);
        lookup(32'h0040_0010, 1, 1, 32'h0040_0200);
        // Bit 31 of the carried target is ignored when comparing
        resolve(32'h0040_0010, 1, 32'h0040_0200, 1, 32'h8040_0200, 0, 0, 32'h0040_0200);
        // Target mismatch with correct direction; counter saturates at the top
        resolve(32'h0040_0010, 1, 32'h0040_0300, 1, 32'h0040_0200, 0, 1, 32'h0040_0300);
        lookup(32'h0040_0010, 1, 1, 32'h0040_0300);
        resolve(32'h0040_0010, 0, 32'h0, 1, 32'h0040_0300, 0, 1, 32'h0040_0014);
        lookup(32'h0040_0010, 1, 1, 32'h0040_0300);
        resolve(32'h0040_0010, 0, 32'h0, 1, 32'h0040_0300, 0, 1, 32'h0040_0014);
        lookup(32'h0040_0010, 1, 0, 32'h0040_0300);

        // Alias on the same index with a different tag replaces the entry
        resolve(alias_pc, 1, 32'h0040_0400, 0, 32'h0, 0, 1, 32'h0040_0400);
        lookup(32'h0040_0010, 0, 0, 32'h0040_0400);
        lookup(alias_pc, 1, 1, 32'h0040_0400);
        resolve(32'h0040_0010, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0040_0014);
        lookup(alias_pc, 1, 1, 32'h0040_0400);

        // Kernel-mode fetch keeps its own bit 31
        resolve(32'h0040_0010, 1, 32'h0040_0100, 0, 32'h0, 0, 1, 32'h0040_0100);
        lookup(32'h8000_0010, 1, 1, 32'h8040_0100);

        // Update and lookup on one index in one cycle: lookup sees the old counter
        @(negedge sysclk);
        if_pc = 32'h0040_0010;
        ex_valid = 1'b1; ex_pc = 32'h0040_0010; ex_taken = 1'b0; ex_target = 32'h0;
        ex_pred_taken = 1'b1; ex_pred_target = 32'h0040_0100;
        expect_val("same_cycle_pred_taken", 32'd1);
        expect_val("same_cycle_mispredict", 32'd1);
        nb++; nm++;
        #2;
        check({31'b0, pred_taken});
        check({31'b0, mispredict});
        @(posedge sysclk);
        #1;
        ex_valid = 1'b0;
        lookup(32'h0040_0010, 1, 0, 32'h0040_0100);

        // Redirect arithmetic wraps in 31 bits and keeps bit 31
        resolve(32'h7FFF_FFFC, 0, 32'h0, 1, 32'h0, 0, 1, 32'h0000_0000);
        resolve(32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0, 0, 0, 32'h8000_0000);
        resolve(32'h8000_0020, 1, 32'h0000_0500, 1, 32'h0000_0500, 0, 0, 32'h8000_0500);
        lookup(32'h0000_0020, 1, 1, 32'h0000_0500);
        lookup(32'h8000_0020, 1, 1, 32'h8000_0500);
        stats_chk();

        // Clear wins over a simultaneous allocate; targets survive, stats keep counting
        resolve(32'h0040_0098, 1, 32'h0040_0900, 0, 32'h0, 1, 1, 32'h0040_0900);
        lookup(32'h0040_0010, 0, 0, 32'h0040_0100);
        lookup(32'h8000_0020, 0, 0, 32'h8000_0500);
        lookup(32'h0040_0098, 0, 0, 32'h0000_0000);
        stats_chk();
        resolve(32'h0040_0098, 1, 32'h0040_0900, 0, 32'h0, 0, 1, 32'h0040_0900);
        lookup(32'h0040_0098, 1, 1, 32'h0040_0900);

        // Async reset across an update edge discards the update and clears everything
        @(negedge sysclk);
        ex_valid = 1'b1; ex_pc = 32'h0040_001C; ex_taken = 1'b1; ex_target = 32'h0040_0700;
        ex_pred_taken = 1'b0;
        #2;
        reset = 1'b0;
        @(negedge sysclk);
        ex_valid = 1'b0;
        reset = 1'b1;
        nb = 0; nm = 0;
        lookup(32'h0040_001C, 0, 0, 32'h0000_0000);
        lookup(32'h0040_0098, 0, 0, 32'h0000_0000);
        stats_chk();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
